// File: rtl/pipe_pkg.sv
// Shared types and constants for the ID->EX pipeline stage.
// Bit positions of the packed control byte and the default payload layout.
package pipe_pkg;

  localparam int unsigned CTRL_W = 8;

  localparam int unsigned CTRL_BRANCH   = 7;
  localparam int unsigned CTRL_MEMREAD  = 6;
  localparam int unsigned CTRL_MEMTOREG = 5;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_REGWRITE = 3;
  localparam int unsigned CTRL_ALUSRC   = 2;
  localparam int unsigned CTRL_ALUOP    = 0;  // aluop occupies [1:0]

  localparam int unsigned XLEN_DEF    = 64;
  localparam int unsigned REG_AW_DEF  = 5;
  localparam int unsigned FUNCT_W_DEF = 4;

  // Field order matches the flat vector packed by id_ex_pipe_stage (ctrl in the LSBs).
  typedef struct packed {
    logic [XLEN_DEF-1:0]    pc;
    logic [XLEN_DEF-1:0]    rs1_data;
    logic [XLEN_DEF-1:0]    rs2_data;
    logic [XLEN_DEF-1:0]    imm;
    logic [REG_AW_DEF-1:0]  rs1;
    logic [REG_AW_DEF-1:0]  rs2;
    logic [REG_AW_DEF-1:0]  rd;
    logic [FUNCT_W_DEF-1:0] funct;
    logic [CTRL_W-1:0]      ctrl;
  } id_ex_payload_t;

  function automatic int unsigned payload_width(input int unsigned xlen,
                                                input int unsigned reg_aw,
                                                input int unsigned funct_w);
    return 4 * xlen + 3 * reg_aw + funct_w + CTRL_W;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline slot: payload register plus valid flag, with load and clear.
// Clear has priority over load and zeroes the stored payload as well as valid.
module pipe_skid_slot #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [Width-1:0] d,
  output logic             valid,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX pipeline register with valid/ready handshake and a one-entry skid slot.
// in_ready comes straight from the skid valid flop, so it never depends on out_ready.
module id_ex_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               bubble,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [REG_AW-1:0]  in_rs1,
  input  logic [REG_AW-1:0]  in_rs2,
  input  logic [REG_AW-1:0]  in_rd,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_rs1_data,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [XLEN-1:0]    out_imm,
  output logic [REG_AW-1:0]  out_rs1,
  output logic [REG_AW-1:0]  out_rs2,
  output logic [REG_AW-1:0]  out_rd,
  output logic [FUNCT_W-1:0] out_funct,
  output logic [CTRL_W-1:0]  out_ctrl
);

  localparam int unsigned PayloadW = payload_width(XLEN, REG_AW, FUNCT_W);

  logic [PayloadW-1:0] in_payload;
  logic [PayloadW-1:0] m_d, m_q, s_q;
  logic                m_valid, s_valid;
  logic                m_load, m_clear, s_load, s_clear;
  logic                accept, drain;
  logic [CTRL_W-1:0]   m_ctrl;

  assign in_payload = {in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd, in_funct,
                       (bubble ? {CTRL_W{1'b0}} : in_ctrl)};

  assign in_ready = !s_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = m_valid & out_ready;

  // Flush overrides every other event; a skid entry refills main as soon as main drains.
  always_comb begin
    m_load  = 1'b0;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    m_d     = in_payload;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else begin
      if (s_valid && drain) begin
        m_load  = 1'b1;
        m_d     = s_q;
        s_clear = 1'b1;
      end else if (accept && (!m_valid || drain)) begin
        m_load = 1'b1;
      end else if (drain && !accept) begin
        m_clear = 1'b1;
      end
      if (accept && m_valid && !drain) begin
        s_load = 1'b1;
      end
    end
  end

  pipe_skid_slot #(
    .Width(PayloadW)
  ) u_main (
    .clk  (clk),
    .reset(reset),
    .load (m_load),
    .clear(m_clear),
    .d    (m_d),
    .valid(m_valid),
    .q    (m_q)
  );

  pipe_skid_slot #(
    .Width(PayloadW)
  ) u_skid (
    .clk  (clk),
    .reset(reset),
    .load (s_load),
    .clear(s_clear),
    .d    (in_payload),
    .valid(s_valid),
    .q    (s_q)
  );

  assign {out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd, out_funct,
          m_ctrl} = m_q;

  assign out_valid = m_valid;
  assign out_ctrl  = m_ctrl & {CTRL_W{m_valid}};

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Scoreboard bench for id_ex_pipe_stage: accepted entries are queued, drained entries are
// popped and compared; directed checks cover handshake timing, flush, bubble and async reset.
module tb_id_ex_pipe_stage;
  import pipe_pkg::*;

  logic                    clk, reset, flush, bubble, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN_DEF-1:0]     in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [XLEN_DEF-1:0]     out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [REG_AW_DEF-1:0]   in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
  logic [FUNCT_W_DEF-1:0]  in_funct, out_funct;
  logic [CTRL_W-1:0]       in_ctrl, out_ctrl;

  int n_cmp = 0;
  int n_fail = 0;
  int n_pushed = 0;
  int n_popped = 0;
  id_ex_payload_t exp_q[$];

  id_ex_pipe_stage #(
    .XLEN   (XLEN_DEF),
    .REG_AW (REG_AW_DEF),
    .FUNCT_W(FUNCT_W_DEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .bubble      (bubble),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_imm      (in_imm),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rd       (in_rd),
    .in_funct    (in_funct),
    .in_ctrl     (in_ctrl),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data),
    .out_imm     (out_imm),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_funct   (out_funct),
    .out_ctrl    (out_ctrl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic id_ex_payload_t mk(input logic [63:0] pc, input logic [7:0] ctrl);
    id_ex_payload_t p;
    p.pc       = pc;
    p.rs1_data = pc ^ 64'h1111_2222_3333_4444;
    p.rs2_data = ~pc;
    p.imm      = pc + 64'd7;
    p.rs1      = pc[6:2];
    p.rs2      = pc[11:7];
    p.rd       = pc[6:2] ^ 5'h15;
    p.funct    = pc[5:2] ^ 4'h9;
    p.ctrl     = ctrl;
    return p;
  endfunction

  task automatic drive(input id_ex_payload_t p);
    in_pc       = p.pc;
    in_rs1_data = p.rs1_data;
    in_rs2_data = p.rs2_data;
    in_imm      = p.imm;
    in_rs1      = p.rs1;
    in_rs2      = p.rs2;
    in_rd       = p.rd;
    in_funct    = p.funct;
    in_ctrl     = p.ctrl;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: model of accept/drain at the sampling point before each rising edge.
  always @(negedge clk) begin
    id_ex_payload_t act, exp;
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        act = {out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd, out_funct,
               out_ctrl};
        n_cmp++;
        n_popped++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got pc %0h, expected no output", out_pc);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            n_fail++;
            $display("FAIL sb_payload: got %h, expected %h", act, exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp = {in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd, in_funct,
               (bubble ? 8'h00 : in_ctrl)};
        exp_q.push_back(exp);
        n_pushed++;
      end
    end
  end

  task automatic send(input id_ex_payload_t p, input logic bub);
    logic acc;
    acc = 1'b0;
    drive(p);
    bubble   = bub;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    bubble   = 1'b0;
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  logic rnd_done;
  int   pop_base;

  initial begin
    reset = 1'b0; flush = 1'b0; bubble = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rnd_done = 1'b0;
    drive(mk(64'h0, 8'h00));
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    #11 reset = 1'b1;
    tick();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(mk(64'(4 * i), 8'hA5 + 8'(i)));
      in_valid = 1'b1;
      tick();
      chk("stream_out_pc", out_pc, 64'(4 * i));
      chk("stream_out_valid", 64'(out_valid), 64'd1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_empty_valid", 64'(out_valid), 64'd0);
    chk("stream_empty_ctrl", 64'(out_ctrl), 64'd0);

    // Back-pressure fills the skid slot.
    out_ready = 1'b0;
    drive(mk(64'h10, 8'h3C));
    in_valid = 1'b1;
    tick();
    chk("bp_in_ready_1", 64'(in_ready), 64'd1);
    drive(mk(64'h14, 8'hC3));
    tick();
    in_valid = 1'b0;
    chk("bp_in_ready_0", 64'(in_ready), 64'd0);
    chk("bp_hold_pc", out_pc, 64'h10);
    tick();
    chk("bp_hold_pc2", out_pc, 64'h10);
    out_ready = 1'b1;
    tick();
    chk("bp_second_pc", out_pc, 64'h14);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush with both slots full and a pending input.
    out_ready = 1'b0;
    drive(mk(64'h18, 8'h11));
    in_valid = 1'b1;
    tick();
    drive(mk(64'h1C, 8'h22));
    tick();
    drive(mk(64'h20, 8'h33));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    // Flush while an accept would otherwise happen.
    drive(mk(64'h24, 8'h44));
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_accept_discard", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_nothing_later", 64'(out_valid), 64'd0);

    // Bubble zeroes control only.
    out_ready = 1'b0;
    drive(mk(64'h30, 8'hFF));
    bubble = 1'b1;
    in_valid = 1'b1;
    tick();
    bubble = 1'b0;
    in_valid = 1'b0;
    chk("bubble_valid", 64'(out_valid), 64'd1);
    chk("bubble_pc", out_pc, 64'h30);
    chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
    out_ready = 1'b1;
    tick();
    bubble = 1'b1;
    tick();
    chk("bubble_no_accept", 64'(out_valid), 64'd0);
    bubble = 1'b0;

    // Async reset mid-cycle with both slots full.
    out_ready = 1'b0;
    drive(mk(64'h40, 8'h5A));
    in_valid = 1'b1;
    tick();
    drive(mk(64'h44, 8'hA5));
    tick();
    in_valid = 1'b0;
    chk("areset_pre_full", 64'(in_ready), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("areset_in_ready", 64'(in_ready), 64'd1);
    chk("areset_pc", out_pc, 64'd0);
    chk("areset_rs1_data", out_rs1_data, 64'd0);
    chk("areset_imm", out_imm, 64'd0);
    chk("areset_regs", 64'({out_rs1, out_rs2, out_rd, out_funct}), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    tick();

    // Random valid/ready traffic against the scoreboard.
    pop_base = n_popped;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          send(mk(64'h1000 + 64'(i) * 4, 8'($urandom)), ($urandom_range(0, 7) == 0));
          repeat ($urandom_range(0, 2)) tick();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick();
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (5) tick();
    chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("rnd_pop_count", 64'(n_popped - pop_base), 64'd400);
    chk("rnd_final_empty", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
